// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/forward sequencer for the 5-stage pipeline, with a mul/div hold FSM and a stall counter.
// Define HAZARD_FORWARD_EN to enable EX/MEM forwarding, which limits data stalls to load-use.
module pipeline_hazard_controller #(
  parameter int MULDIV_LATENCY = 4,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_usesRs,
  input  logic                   id_usesRt,
  input  logic                   id_branchTaken,
  input  logic [4:0]             ex_registerWriteBackDestination,
  input  logic                   ex_ifWriteRegsFile,
  input  logic                   ex_isLoad,
  input  logic                   ex_isMulDiv,
  input  logic [4:0]             mem_registerWriteBackDestination,
  input  logic                   mem_ifWriteRegsFile,
  input  logic                   clear_stall_cnt,
  output logic                   pc_writeEnable,
  output logic                   ifid_writeEnable,
  output logic                   ifid_flush,
  output logic                   idex_writeEnable,
  output logic                   idex_flush,
  output logic                   exmem_flush,
  output logic                   muldiv_start,
  output logic [1:0]             forward_a,
  output logic [1:0]             forward_b,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [3:0] MD_LOAD = 4'(MULDIV_LATENCY - 2);

  state_t                 state, next_state;
  logic [3:0]             md_cnt, md_cnt_next;
  logic [STALL_CNT_W-1:0] cnt;

  logic ex_rs_match, ex_rt_match, mem_rs_match, mem_rt_match;
  logic data_stall;
  logic [1:0] fwd_a, fwd_b;

  // Register 0 is hardwired, so it can never be the source of a hazard.
  assign ex_rs_match  = id_usesRs && ex_ifWriteRegsFile &&
                        (ex_registerWriteBackDestination != 5'd0) &&
                        (ex_registerWriteBackDestination == id_rs);
  assign ex_rt_match  = id_usesRt && ex_ifWriteRegsFile &&
                        (ex_registerWriteBackDestination != 5'd0) &&
                        (ex_registerWriteBackDestination == id_rt);
  assign mem_rs_match = id_usesRs && mem_ifWriteRegsFile &&
                        (mem_registerWriteBackDestination != 5'd0) &&
                        (mem_registerWriteBackDestination == id_rs);
  assign mem_rt_match = id_usesRt && mem_ifWriteRegsFile &&
                        (mem_registerWriteBackDestination != 5'd0) &&
                        (mem_registerWriteBackDestination == id_rt);

`ifdef HAZARD_FORWARD_EN
  assign data_stall = ex_isLoad && (ex_rs_match || ex_rt_match);
  assign fwd_a = (ex_rs_match && !ex_isLoad) ? 2'b10 : (mem_rs_match ? 2'b01 : 2'b00);
  assign fwd_b = (ex_rt_match && !ex_isLoad) ? 2'b10 : (mem_rt_match ? 2'b01 : 2'b00);
`else
  logic unused_load;
  assign unused_load = ex_isLoad;
  assign data_stall  = ex_rs_match || ex_rt_match || mem_rs_match || mem_rt_match;
  assign fwd_a       = 2'b00;
  assign fwd_b       = 2'b00;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= 4'd0;
    end else begin
      state  <= next_state;
      md_cnt <= md_cnt_next;
    end
  end

  // Priority: mul/div hold, then data stall, then branch flush.
  always_comb begin
    next_state       = state;
    md_cnt_next      = md_cnt;
    pc_writeEnable   = 1'b1;
    ifid_writeEnable = 1'b1;
    idex_writeEnable = 1'b1;
    ifid_flush       = 1'b0;
    idex_flush       = 1'b0;
    exmem_flush      = 1'b0;
    muldiv_start     = 1'b0;
    forward_a        = fwd_a;
    forward_b        = fwd_b;
    if (rst) begin
      pc_writeEnable   = 1'b0;
      ifid_writeEnable = 1'b0;
      idex_writeEnable = 1'b0;
      ifid_flush       = 1'b1;
      idex_flush       = 1'b1;
      exmem_flush      = 1'b1;
      forward_a        = 2'b00;
      forward_b        = 2'b00;
    end else begin
      case (state)
        RUN: begin
          if (ex_isMulDiv) begin
            muldiv_start     = 1'b1;
            pc_writeEnable   = 1'b0;
            ifid_writeEnable = 1'b0;
            idex_writeEnable = 1'b0;
            exmem_flush      = 1'b1;
            md_cnt_next      = MD_LOAD;
            next_state       = MD_BUSY;
          end else if (data_stall) begin
            pc_writeEnable   = 1'b0;
            ifid_writeEnable = 1'b0;
            idex_flush       = 1'b1;
          end else if (id_branchTaken) begin
            ifid_flush       = 1'b1;
          end
        end
        MD_BUSY: begin
          if (md_cnt != 4'd0) begin
            pc_writeEnable   = 1'b0;
            ifid_writeEnable = 1'b0;
            idex_writeEnable = 1'b0;
            exmem_flush      = 1'b1;
            md_cnt_next      = md_cnt - 4'd1;
          end else begin
            next_state       = RUN;
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  // Clear beats increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear_stall_cnt) begin
      cnt <= '0;
    end else if (!pc_writeEnable && (cnt != {STALL_CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign stall_cnt = cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: directed vectors push expectations, a negedge monitor compares.
// Expected values follow HAZARD_FORWARD_EN when the bench is built with it.
module tb_pipeline_hazard_controller;

  typedef struct packed {
    logic       r;
    logic [4:0] rs, rt;
    logic       urs, urt, br;
    logic [4:0] exd;
    logic       exw, ld, md;
    logic [4:0] memd;
    logic       memw, clr;
  } stim_t;

  typedef struct {
    logic [10:0] o;
    logic [3:0]  c;
    string       name;
  } exp_t;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Bit order: pc_we, ifid_we, idex_we, ifid_fl, idex_fl, exmem_fl, start, fa[1:0], fb[1:0]
  localparam logic [10:0] E_RUN   = 11'b111_000_0_00_00;
  localparam logic [10:0] E_RST   = 11'b000_111_0_00_00;
  localparam logic [10:0] E_START = 11'b000_001_1_00_00;
  localparam logic [10:0] E_HOLD  = 11'b000_001_0_00_00;
  localparam logic [10:0] E_STALL = 11'b001_010_0_00_00;
  localparam logic [10:0] E_BR    = 11'b111_100_0_00_00;
  localparam logic [10:0] FA01    = 11'b000_000_0_01_00;
  localparam logic [10:0] FA10    = 11'b000_000_0_10_00;
  localparam logic [10:0] FB01    = 11'b000_000_0_00_01;
  localparam logic [10:0] FB10    = 11'b000_000_0_00_10;

  logic clk;
  stim_t s;
  exp_t sb[$];
  exp_t item;
  logic [3:0] exp_cnt;
  int n_vec, n_miss;

  logic pc_writeEnable, ifid_writeEnable, ifid_flush, idex_writeEnable;
  logic idex_flush, exmem_flush, muldiv_start;
  logic [1:0] forward_a, forward_b;
  logic [3:0] stall_cnt;

  pipeline_hazard_controller #(.MULDIV_LATENCY(4), .STALL_CNT_W(4)) dut (
    .clk                              (clk),
    .rst                              (s.r),
    .id_rs                            (s.rs),
    .id_rt                            (s.rt),
    .id_usesRs                        (s.urs),
    .id_usesRt                        (s.urt),
    .id_branchTaken                   (s.br),
    .ex_registerWriteBackDestination  (s.exd),
    .ex_ifWriteRegsFile               (s.exw),
    .ex_isLoad                        (s.ld),
    .ex_isMulDiv                      (s.md),
    .mem_registerWriteBackDestination (s.memd),
    .mem_ifWriteRegsFile              (s.memw),
    .clear_stall_cnt                  (s.clr),
    .pc_writeEnable                   (pc_writeEnable),
    .ifid_writeEnable                 (ifid_writeEnable),
    .ifid_flush                       (ifid_flush),
    .idex_writeEnable                 (idex_writeEnable),
    .idex_flush                       (idex_flush),
    .exmem_flush                      (exmem_flush),
    .muldiv_start                     (muldiv_start),
    .forward_a                        (forward_a),
    .forward_b                        (forward_b),
    .stall_cnt                        (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t st(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic br,
                               input logic [4:0] exd, input logic exw, input logic ld,
                               input logic md, input logic [4:0] memd, input logic memw,
                               input logic clr);
    stim_t v;
    v = '{r, rs, rt, urs, urt, br, exd, exw, ld, md, memd, memw, clr};
    return v;
  endfunction

  // The counter model trails by a cycle: a stall vector shows up in stall_cnt of the next vector.
  task automatic applyStimulus(input stim_t v, input logic [10:0] e, input string name);
    exp_t x;
    @(posedge clk);
    #1;
    s = v;
    x.o = e;
    x.c = v.r ? 4'd0 : exp_cnt;
    x.name = name;
    sb.push_back(x);
    if (v.r || v.clr) exp_cnt = 4'd0;
    else if (!e[10] && exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
  endtask

  task automatic checkOutput(input exp_t x);
    logic [10:0] act;
    act = {pc_writeEnable, ifid_writeEnable, idex_writeEnable, ifid_flush, idex_flush,
           exmem_flush, muldiv_start, forward_a, forward_b};
    n_vec++;
    if (act !== x.o || stall_cnt !== x.c) begin
      n_miss++;
      $display("[TB] FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
               x.name, act, stall_cnt, x.o, x.c);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item = sb.pop_front();
      checkOutput(item);
    end
  end

  initial begin
    stim_t idle, lu;
    n_vec = 0;
    n_miss = 0;
    exp_cnt = 4'd0;
    s = st(1, 0,0,0,0,0, 0,0,0,0, 0,0,0);
    idle = st(0, 0,0,0,0,0, 0,0,0,0, 0,0,0);
    lu   = st(0, 5,0,1,0,0, 5,1,1,0, 0,0,0);

    applyStimulus(st(1, 0,0,0,0,0, 0,0,0,0, 0,0,0), E_RST, "reset");
    applyStimulus(idle, E_RUN, "idle");
    applyStimulus(st(0, 0,0,0,0,1, 0,0,0,0, 0,0,0), E_BR, "branch");
    applyStimulus(idle, E_RUN, "after_branch");

    applyStimulus(lu, E_STALL, "load_use");
    applyStimulus(st(0, 5,0,1,0,0, 0,0,0,0, 5,1,0), FWD ? (E_RUN | FA01) : E_STALL, "lu_mem");
    applyStimulus(idle, E_RUN, "idle2");
    applyStimulus(st(0, 0,0,1,0,0, 0,1,1,0, 0,1,0), E_RUN, "r0_no_match");
    applyStimulus(st(0, 0,7,0,1,0, 7,1,0,0, 0,0,0), FWD ? (E_RUN | FB10) : E_STALL, "ex_rt_match");
    applyStimulus(st(0, 0,7,0,1,0, 0,0,0,0, 7,1,0), FWD ? (E_RUN | FB01) : E_STALL, "mem_rt_match");
    applyStimulus(st(0, 3,0,1,0,0, 3,1,0,0, 3,1,0), FWD ? (E_RUN | FA10) : E_STALL, "ex_over_mem");
    applyStimulus(st(0, 4,0,0,0,0, 4,1,0,0, 4,1,0), E_RUN, "rs_unused");

    applyStimulus(st(0, 0,0,0,0,0, 9,1,0,1, 0,0,0), E_START, "md_start");
    applyStimulus(st(0, 0,0,0,0,1, 9,1,0,1, 0,0,0), E_HOLD, "md_hold1");
    applyStimulus(st(0, 0,0,0,0,1, 9,1,0,1, 0,0,0), E_HOLD, "md_hold2");
    applyStimulus(st(0, 0,0,0,0,0, 9,1,0,1, 0,0,0), E_RUN, "md_release");
    applyStimulus(idle, E_RUN, "md_after");

    applyStimulus(st(0, 0,6,0,1,1, 6,1,1,0, 0,0,0), E_STALL, "br_load_use");
    applyStimulus(st(0, 0,6,0,1,1, 0,0,0,0, 6,1,0), FWD ? (E_BR | FB01) : E_STALL, "br_after_lu");
    applyStimulus(st(0, 0,0,0,0,1, 0,0,0,0, 0,0,0), E_BR, "br_clear");

    applyStimulus(st(0, 0,0,0,0,0, 9,1,0,1, 0,0,0), E_START, "md2_start");
    applyStimulus(st(0, 0,0,0,0,0, 9,1,0,1, 0,0,0), E_HOLD, "md2_hold");
    applyStimulus(st(1, 0,0,0,0,0, 9,1,0,1, 0,0,0), E_RST, "md_reset");
    applyStimulus(idle, E_RUN, "post_reset");

    applyStimulus(st(0, 0,0,0,0,0, 0,0,0,0, 0,0,1), E_RUN, "clear");
    for (int i = 0; i < 20; i++) applyStimulus(lu, E_STALL, "sat_stall");
    applyStimulus(idle, E_RUN, "saturated");
    applyStimulus(st(0, 5,0,1,0,0, 5,1,1,0, 0,0,1), E_STALL, "clear_with_stall");
    applyStimulus(idle, E_RUN, "cleared");

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_miss++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
